// File: rtl/nibble_logic_sequencer.sv
// Multi-cycle WIDTH-bit bitwise logic controller that drives an external SLICE-bit
// logic unit one slice per cycle, LSB slice first, and assembles the full result.
module nibble_logic_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic [SLICE-1:0] slice_a_o,
  output logic [SLICE-1:0] slice_b_o,
  output logic [1:0]       slice_op_o,
  input  logic [SLICE-1:0] slice_r_i,
  output logic [1:0]       state_o
);

  // WIDTH must be a whole multiple of SLICE; N is not meant to be overridden.
  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  // Handshake: start_i is a level sampled at every rising edge; it is accepted only in
  // IDLE or DONE (never queued during RUN), and done_o is a one-cycle result-valid pulse.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    zero_d     = zero_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    slice_a_o  = '0;
    slice_b_o  = '0;
    slice_op_o = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done_o = (state_q == S_DONE);
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = op_i;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        busy_o     = 1'b1;
        slice_a_o  = a_q[idx_q*SLICE +: SLICE];
        slice_b_o  = b_q[idx_q*SLICE +: SLICE];
        slice_op_o = op_q;
        result_d[idx_q*SLICE +: SLICE] = slice_r_i;
        if (idx_q == LAST_IDX) begin
          // Zero flag looks at the result including the slice captured on this edge.
          idx_d   = '0;
          zero_d  = (result_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign state_o  = state_q;

endmodule

// File: doc/nibble_logic_sequencer.md
# nibble_logic_sequencer

Multi-cycle controller that performs WIDTH-bit bitwise logic operations by sequencing an external SLICE-bit logic unit (AND/OR/XOR/AND-NOT slice) once per slice, least-significant slice first. It sits between the ALU decode path and the shared narrow logic slice. It latches operands on a start pulse, drives one slice per cycle, assembles the full result, and signals completion with a single-cycle done pulse and a zero flag.

## Interface

- WIDTH, 32, operand/result width; must be an integer multiple of SLICE
- SLICE, 4, width of the external logic slice
- N (derived, not overridable), WIDTH/SLICE, number of slice steps

- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled each rising edge
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 AND-NOT (a & ~b)
- a  in  WIDTH  operand A, sampled with accepted start
- b  in  WIDTH  operand B, sampled with accepted start
- busy  out  1  high while slices are being processed
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  assembled result, held until next accepted start
- zero  out  1  result == 0, valid with done and held with result
- slice_a  out  SLICE  current slice of latched A
- slice_b  out  SLICE  current slice of latched B
- slice_op  out  2  latched op forwarded to slice unit
- slice_r  in  SLICE  combinational result from slice unit for current slice

## Operation

- States: IDLE, RUN, DONE. Slice counter idx ranges 0..N-1, width ceil(log2 N), minimum 1.
- IDLE: busy=0, done=0. start=1 latches a, b, op; clears idx to 0; moves to RUN. result and zero are not modified on acceptance.
- RUN: busy=1.
  - slice_a = a_q[idx*SLICE +: SLICE]; slice_b is derived likewise; slice_op = op_q.
  - Each edge writes slice_r into result_q[idx*SLICE +: SLICE] and increments idx.
  - On the edge where idx==N-1, the final slice is captured. idx wraps to 0, the state moves to DONE, and zero is computed from the complete assembled result.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation) and moves to RUN. Otherwise the next state is IDLE.
- start in RUN is ignored; it is not queued.
- In IDLE and DONE, slice_a, slice_b and slice_op are driven to 0.
- result and zero update only at slice capture and completion. Outside RUN they hold their last value.

## Timing

- Reset (reset=0, asynchronous): state=IDLE, idx=0, busy=0, done=0, result=0, zero=0, latched operands=0, slice outputs=0.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is generated and result is cleared to 0.
- Reset is released synchronously in effect: the first start is sampled on the first rising edge with reset=1.
- Latency, with start sampled at edge 0:
  - RUN occupies the cycles following edges 0..N-1.
  - Slices are captured at edges 1..N.
  - done is high in the cycle following edge N.
  - Start-to-done is N+1 edges; 9 for WIDTH=32, SLICE=4.
- Throughput: one operation per N+1 cycles with back-to-back starts.
- slice_r is sampled in the same cycle its slice is driven. The slice unit must settle within one clock period.
- busy and done are never high together.

## Test plan

- AND with a=0xFFFF0000, b=0x0F0F0F0F, op=00 -> done exactly 9 edges after start; result=0x0F0F0000, zero=0. slice_a observed as 0,0,0,0,F,F,F,F across RUN.
- OR/XOR/AND-NOT on the same operands (op=01/10/11) -> result 0xFFFF0F0F / 0xF0F00F0F / 0xF0F00000 respectively, each with zero=0.
- AND with a=0xAAAAAAAA, b=0x55555555 -> result=0x00000000, zero=1. result and zero held for 5 idle cycles after done.
- start pulsed again during RUN (at cycle 3) with different operands -> ignored; result matches first operands and exactly one done pulse occurs. Then start held high continuously -> back-to-back operations with done every 9 cycles.
- reset driven low in cycle 4 of RUN -> busy=0, result=0, slice outputs=0 immediately. No done pulse appears. After reset release, a new AND 0x12345678 & 0xFFFFFFFF -> result=0x12345678.
- Parameter variant WIDTH=8, SLICE=4: a=0xC3, b=0x0F, op=10 -> done 3 edges after start, result=0xCC.
